stream_join_fork_buffer: RTL and testbench
==========================================

Name: stream_join_fork_buffer

Overview:
- Parametrised successor to the single-input, single-output stream buffer nodes used between kernels in the generated dataflow top.
- Joins NIN input streams into one lane-aligned FIFO entry.
- Buffers up to DEPTH entries.
- Broadcasts the head entry to NOUT consumers as an eager fork: each consumer accepts independently. This removes the AND-of-successor-readies stall coupling of the current scheme.

Parameters:
- STREAMW, 34: bits per stream lane.
- NIN, 2: number of joined input streams (≥1).
- NOUT, 2: number of fork consumers (≥1).
- DEPTH, 4: FIFO entries (≥2, any integer, not required to be a power of 2).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset; asynchronous assert, active-low, synchronous deassert handled externally.
- ivalid  input  NIN  per-input valid.
- iready  output  1  shared ready to all NIN producers.
- in_data  input  NIN*STREAMW  lane i occupies bits [i*STREAMW +: STREAMW].
- ovalid  output  NOUT  per-consumer valid.
- oready  input  NOUT  per-consumer ready.
- out_data  output  NIN*STREAMW  head entry, broadcast to all consumers.
- count  output  clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - rd_ptr, wr_ptr, count and served mask cleared immediately.
  - ovalid=0, iready=0 while rst=0.
  - out_data is don't-care but must not be X after the first write.
  - Reset mid-transfer discards all stored entries and any partial fork progress.
- Join:
  - join_valid = &ivalid.
  - iready = rst & (count != DEPTH). It must not depend on ivalid or oready, so no combinational path exists.
  - Push when join_valid & iready. All NIN lanes are written into one entry.
  - A producer whose ivalid is high while others are low is not consumed.
- Storage and pointers:
  - Registered array, DEPTH × NIN*STREAMW.
  - wr_ptr and rd_ptr increment modulo DEPTH. Wrap from DEPTH-1 to 0 uses an explicit compare.
- Latency: an entry pushed in cycle t appears on out_data with ovalid in cycle t+1 (first-word-fall-through).
- Fork:
  - served[NOUT-1:0] register. Bit k is set once consumer k has taken the current head.
  - ovalid[k] = (count != 0) & ~served[k].
  - take[k] = ovalid[k] & oready[k].
  - Pop when (served | take) is all ones. On pop, served is cleared and rd_ptr advances. Otherwise served |= take.
  - A consumer that has taken the head sees ovalid low until the next entry becomes head. It never receives a duplicate.
- Count:
  - +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full:
  - iready=0 even if a pop occurs in the same cycle; push is not permitted through a full buffer.
  - The following cycle iready=1.
- Empty: ovalid all 0. out_data holds the last head value.
- NOUT=1 degenerates to a plain FIFO. NIN=1 degenerates to a single-input buffer. Both must synthesise.

Optional Feature:
- Macro: TYTRA_BUF_BYPASS_EN.
- Defined, the buffer adds a zero-latency bypass:
  - When count==0 and join_valid & iready, out_data = in_data combinationally and ovalid[k] = ~served[k] in the same cycle.
  - If every consumer takes in that cycle, nothing is written and count stays 0.
  - If only some consumers take, the entry is written and served records the takers. The entry then continues as a normal head.
  - This introduces a combinational ivalid→ovalid path.
- Undefined: latency is strictly 1 cycle and all outputs except out_data mux select are registered-state driven.

Test Plan:
- Reset then ivalid=2'b11, in_data={34'h2,34'h1}, oready=2'b11 for one cycle → cycle+1: ovalid=2'b11, out_data={2,1}; cycle+2: count=0, ovalid=0 (bypass off).
- ivalid=2'b01 held 5 cycles → no push, count=0, iready=1 throughout.
- DEPTH=4, oready=0, push 6 entries (values 10..15) → count=4 after 4 pushes, iready=0, entries 14 and 15 are held off. Then oready=2'b11 → drains 10,11,12,13 in order with one pop per cycle. Pointer wrap is then verified by pushing 14,15 and reading them back.
- Head=0x55, oready=2'b01 in cycle t, 2'b10 in t+1 → ovalid goes 11 → 10 in t+1, pop in t+1. Consumer 0 never sees 0x55 twice.
- Full buffer with oready=2'b11 and ivalid=2'b11 in the same cycle → pop occurs, no push, count 4→3; next cycle push, count back to 4.
- Assert rst=0 asynchronously mid-cycle with count=3 and served=2'b01 → ovalid=0 and iready=0 immediately. After release: count=0, served=0, iready=1.

Source files
------------

// File: rtl/stream_join_fork_buffer.sv
// Joins NIN valid/ready streams into one lane-aligned FIFO entry and eagerly forks the head to NOUT consumers.
// Latency: push in cycle t is visible on out_data/ovalid in t+1; TYTRA_BUF_BYPASS_EN adds a zero-latency path when empty.
// Backpressure: iready drops only on a full buffer, so it never depends on ivalid or oready; each consumer stalls independently.
module stream_join_fork_buffer #(
    parameter int STREAMW = 34,
    parameter int NIN     = 2,
    parameter int NOUT    = 2,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NIN-1:0]               ivalid,
    output logic                         iready,
    input  logic [NIN*STREAMW-1:0]       in_data,
    output logic [NOUT-1:0]              ovalid,
    input  logic [NOUT-1:0]              oready,
    output logic [NIN*STREAMW-1:0]       out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int W  = NIN * STREAMW;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   last_ptr;
    logic [NOUT-1:0] served;
    logic [NOUT-1:0] take;
    logic [NOUT-1:0] served_all;
    logic            join_valid;
    logic            push_req;
    logic            bypass;
    logic            has_head;
    logic            all_done;
    logic            pop;
    logic            wr_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign join_valid = &ivalid;
    assign iready     = rst & (count != CW'(DEPTH));
    assign push_req   = join_valid & iready;

`ifdef TYTRA_BUF_BYPASS_EN
    assign bypass = (count == '0) & push_req;
`else
    assign bypass = 1'b0;
`endif

    assign has_head   = (count != '0) | bypass;
    assign ovalid     = {NOUT{has_head}} & ~served;
    assign take       = ovalid & oready;
    assign served_all = served | take;
    assign all_done   = has_head & (&served_all);
    assign pop        = all_done & (count != '0);
    // A bypassed entry that every consumer took is never stored.
    assign wr_en      = push_req & ~(bypass & all_done);

    // When empty, keep presenting the most recently popped head.
    always_comb begin
        out_data = (count != '0) ? mem[rd_ptr] : mem[last_ptr];
`ifdef TYTRA_BUF_BYPASS_EN
        if (bypass) begin
            out_data = in_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_ptr <= '0;
            count    <= '0;
            served   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                last_ptr <= rd_ptr;
            end
            served <= all_done ? '0 : served_all;
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end
endmodule

// File: tb/tb_stream_join_fork_buffer.sv
// Directed bench for stream_join_fork_buffer (NIN=2, NOUT=2, DEPTH=4) with a per-consumer scoreboard.
module tb_stream_join_fork_buffer;
    localparam int STREAMW = 34;
    localparam int NIN     = 2;
    localparam int NOUT    = 2;
    localparam int DEPTH   = 4;
    localparam int W       = NIN * STREAMW;

    logic            clk;
    logic            rst;
    logic [NIN-1:0]  ivalid;
    logic            iready;
    logic [W-1:0]    in_data;
    logic [NOUT-1:0] ovalid;
    logic [NOUT-1:0] oready;
    logic [W-1:0]    out_data;
    logic [2:0]      count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q [NOUT][$];

    stream_join_fork_buffer #(
        .STREAMW(STREAMW), .NIN(NIN), .NOUT(NOUT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready), .in_data(in_data),
        .ovalid(ovalid), .oready(oready), .out_data(out_data), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input logic [STREAMW-1:0] hi, input logic [STREAMW-1:0] lo);
        return {hi, lo};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted joins, then check every consumer handshake against its queue.
    always @(negedge clk) begin
        if ((&ivalid) && iready) begin
            for (int k = 0; k < NOUT; k++) exp_q[k].push_back(in_data);
        end
        for (int k = 0; k < NOUT; k++) begin
            if (ovalid[k] && oready[k]) begin
                n_checks++;
                if (exp_q[k].size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected[%0d]: got %0h expected no transfer", k, out_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q[k].pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL sb_data[%0d]: got %0h expected %0h", k, out_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ivalid = '0; in_data = '0; oready = '0;
        @(negedge clk);
        check("rst_iready", W'(iready), W'(0));
        check("rst_ovalid", W'(ovalid), W'(0));
        check("rst_count",  W'(count),  W'(0));
        step(); rst = 1'b1;
        @(negedge clk);
        check("post_rst_iready", W'(iready), W'(1));

        // Single join and fork with one-cycle latency
        step(); ivalid = 2'b11; in_data = pack(34'h2, 34'h1); oready = 2'b11;
        @(negedge clk);
        check("t1_ovalid_c0", W'(ovalid), W'(0));
        step(); ivalid = 2'b00;
        @(negedge clk);
        check("t1_ovalid_c1", W'(ovalid), W'(2'b11));
        check("t1_count_c1",  W'(count),  W'(1));
        step();
        @(negedge clk);
        check("t1_count_c2",  W'(count),  W'(0));
        check("t1_ovalid_c2", W'(ovalid), W'(0));

        // Partial valid is never consumed
        step(); ivalid = 2'b01; in_data = pack(34'h7, 34'h7);
        repeat (5) begin
            @(negedge clk);
            check("partial_count",  W'(count),  W'(0));
            check("partial_iready", W'(iready), W'(1));
            step();
        end
        ivalid = 2'b00; oready = 2'b00;

        // Fill to full, hold off, then drain in order
        for (int v = 10; v < 14; v++) begin
            in_data = pack(STREAMW'(v), STREAMW'(v)); ivalid = 2'b11;
            step();
        end
        for (int v = 14; v < 16; v++) begin
            in_data = pack(STREAMW'(v), STREAMW'(v));
            @(negedge clk);
            check("full_count",  W'(count),  W'(4));
            check("full_iready", W'(iready), W'(0));
            step();
        end
        ivalid = 2'b00; oready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_count",  W'(count),  W'(4 - i));
            check("drain_ovalid", W'(ovalid), W'(2'b11));
            step();
        end
        @(negedge clk);
        check("drain_empty", W'(count), W'(0));
        in_data = pack(34'd14, 34'd14); ivalid = 2'b11;
        step(); in_data = pack(34'd15, 34'd15);
        step(); ivalid = 2'b00;
        step(); step();
        @(negedge clk);
        check("wrap_empty", W'(count), W'(0));

        // Consumers take the head in different cycles
        oready = 2'b00; in_data = pack(34'h55, 34'h55); ivalid = 2'b11;
        step(); ivalid = 2'b00; oready = 2'b01;
        @(negedge clk);
        check("fork_ovalid_t",  W'(ovalid), W'(2'b11));
        step(); oready = 2'b10;
        @(negedge clk);
        check("fork_ovalid_t1", W'(ovalid), W'(2'b10));
        step(); oready = 2'b00;
        @(negedge clk);
        check("fork_count", W'(count), W'(0));
        check("fork_idle",  W'(ovalid), W'(0));

        // Full buffer: pop allowed, push refused in the same cycle
        for (int v = 20; v < 24; v++) begin
            in_data = pack(STREAMW'(v), STREAMW'(v)); ivalid = 2'b11;
            step();
        end
        in_data = pack(34'd24, 34'd24); oready = 2'b11;
        @(negedge clk);
        check("fullpop_iready", W'(iready), W'(0));
        check("fullpop_count",  W'(count),  W'(4));
        step(); oready = 2'b00;
        @(negedge clk);
        check("fullpop_count_next",  W'(count),  W'(3));
        check("fullpop_iready_next", W'(iready), W'(1));
        step(); ivalid = 2'b00;
        @(negedge clk);
        check("fullpop_refill", W'(count), W'(4));
        step(); oready = 2'b11;
        repeat (4) step();
        @(negedge clk);
        check("fullpop_drained", W'(count), W'(0));
        oready = 2'b00;

        // Asynchronous reset with partial fork progress
        step();
        for (int v = 30; v < 33; v++) begin
            in_data = pack(STREAMW'(v), STREAMW'(v)); ivalid = 2'b11;
            step();
        end
        ivalid = 2'b00; oready = 2'b01;
        step(); oready = 2'b00;
        @(negedge clk);
        check("pre_rst_count",  W'(count),  W'(3));
        check("pre_rst_ovalid", W'(ovalid), W'(2'b10));
        #2; rst = 1'b0;
        #1;
        check("async_rst_ovalid", W'(ovalid), W'(0));
        check("async_rst_iready", W'(iready), W'(0));
        check("async_rst_count",  W'(count),  W'(0));
        for (int k = 0; k < NOUT; k++) exp_q[k].delete();
        step(); rst = 1'b1;
        @(negedge clk);
        check("rel_count",  W'(count),  W'(0));
        check("rel_iready", W'(iready), W'(1));
        check("rel_ovalid", W'(ovalid), W'(0));
        step(); in_data = pack(34'd40, 34'd40); ivalid = 2'b11;
        step(); ivalid = 2'b00; oready = 2'b11;
        @(negedge clk);
        check("rel_served_clear", W'(ovalid), W'(2'b11));
        step(); oready = 2'b00;
        @(negedge clk);
        check("rel_final_count", W'(count), W'(0));

        for (int k = 0; k < NOUT; k++) check("sb_leftover", W'(exp_q[k].size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
